// File: rtl/timer_dev_if.sv
// Bus-side port bundle of the timer: word-select, write strobe, data in/out, interrupt.
// Latency: none of its own; it only carries wires between the bus master and the timer.
// Backpressure: none; every access completes in a single cycle.
interface timer_dev_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (output Addr, output WE, output DIn, input DOut, input IRQ);
  modport slave  (input Addr, input WE, input DIn, output DOut, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Down-counting timer with CTRL/PRESET/COUNT registers, one-shot or auto-reload modes, masked IRQ.
// Latency: reads are combinational; writes land at the clock edge; IRQ rises PRESET+2 edges after Enable is written.
// Backpressure: none; the bus can never stall and every write is taken in one cycle.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctrl;      // [0] Enable, [2:1] Mode, [3] IM
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic        pending;
  logic        pending_set;
  logic        pending_clr;
  logic        en_clr;
  logic        ctrl_wr;
  logic        preset_wr;

  assign ctrl_wr   = bus.WE && (bus.Addr == 2'd0);
  assign preset_wr = bus.WE && (bus.Addr == 2'd1);

  // Next-state and counter datapath; COUNT of 0 or 1 both expire so the count never wraps.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pending_set = 1'b0;
    pending_clr = 1'b0;
    en_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl[0]) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_nxt = IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt   = 32'd0;
          pending_set = 1'b1;
          state_nxt   = INT;
        end
      end
      INT: begin
        if (ctrl[2:1] == 2'd1) begin
          pending_clr = 1'b1;
          state_nxt   = LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and COUNT registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // CTRL register; a bus write takes priority over the one-shot Enable clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= 4'd0;
    end else if (ctrl_wr) begin
      ctrl <= bus.DIn[3:0];
    end else if (en_clr) begin
      ctrl[0] <= 1'b0;
    end
  end

  // PRESET register; only sampled by LOAD, so writing it never disturbs a running count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= 32'd0;
    end else if (preset_wr) begin
      preset <= bus.DIn;
    end
  end

  // Pending flag; any CTRL write acknowledges it, even against a simultaneous expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (ctrl_wr) begin
      pending <= 1'b0;
    end else if (pending_set) begin
      pending <= 1'b1;
    end else if (pending_clr) begin
      pending <= 1'b0;
    end
  end

  // Zero-latency read mux; reserved word reads as zero.
  always_comb begin
    bus.DOut = 32'd0;
    case (bus.Addr)
      2'd0:    bus.DOut = {28'd0, ctrl};
      2'd1:    bus.DOut = preset;
      2'd2:    bus.DOut = count;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IRQ = ctrl[3] & pending;

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Addr, input, 2 bits: word select taken from bus address bits [3:2]. 0 selects CTRL, 1 selects PRESET, 2 selects COUNT, 3 is reserved.
REQ-004 SHALL have port WE, input, 1 bit: bus write strobe, already qualified by the bridge's device select.
REQ-005 SHALL have port DIn, input, 32 bits: bus write data.
REQ-006 SHALL have port DOut, output, 32 bits: bus read data.
REQ-007 SHALL have port IRQ, output, 1 bit: interrupt request, routed to a CPU HWInt line.

Function
REQ-008 SHALL hold three registers:
- CTRL: bit 0 Enable, bits [2:1] Mode, bit 3 IM (interrupt mask); bits [31:4] read 0.
- PRESET: 32-bit reload value.
- COUNT: 32 bits, read-only.
REQ-009 DOut SHALL be combinational from Addr, with no read latency:
- Addr 0 returns {28'b0, CTRL[3:0]}.
- Addr 1 returns PRESET.
- Addr 2 returns COUNT.
- Addr 3 returns 0.
REQ-010 A write with WE=1 SHALL update the addressed register at the clock edge:
- Addr 0 writes DIn[3:0] into CTRL.
- Addr 1 writes PRESET.
- Addr 2 and Addr 3 are ignored.
REQ-011 The FSM SHALL have the states IDLE, LOAD, CNT and INT.
REQ-012 IDLE SHALL move to LOAD when Enable=1; otherwise it stays in IDLE and COUNT holds.
REQ-013 LOAD SHALL set COUNT<=PRESET and move to CNT.
REQ-014 CNT SHALL behave as follows:
- If Enable=0: move to IDLE, COUNT holds.
- Else if COUNT>1: COUNT<=COUNT-1.
- Else (COUNT is 0 or 1): COUNT<=0, pending<=1, move to INT.
REQ-015 INT SHALL behave according to Mode:
- Mode 0: Enable<=0, move to IDLE, pending holds.
- Mode 1: move to LOAD, pending<=0.
- Modes 2 and 3 behave as Mode 0.
REQ-016 IRQ SHALL equal IM & pending, with the pending flag registered. In Mode 1 IRQ is therefore a one-cycle pulse.
REQ-017 Any write to CTRL SHALL clear pending.
REQ-018 A PRESET write SHALL NOT disturb COUNT; it takes effect at the next LOAD.
REQ-019 When a CTRL write and the INT-state Enable clear occur at the same edge, the CTRL write SHALL win.
REQ-020 Writing Enable=1 while in CNT SHALL NOT restart the count. Writing Enable=0 and then Enable=1 SHALL resume from IDLE through LOAD, reloading from PRESET.
REQ-021 PRESET=0 or PRESET=1 SHALL reach INT on the first CNT cycle.
REQ-022 COUNT SHALL never wrap below 0.
REQ-023 Latency: with PRESET=N (N≥1), IRQ SHALL rise at the (N+2)th rising edge after the edge that writes Enable=1, counting that edge as edge 0.

Reset
REQ-024 While reset=0, asynchronously and independent of clk:
- state=IDLE
- CTRL=0, PRESET=0, COUNT=0
- pending=0, IRQ=0
- DOut follows REQ-009 with all registers at 0.
REQ-025 Reset asserted mid-count SHALL abort the count with no IRQ. After release the block stays in IDLE until software sets Enable.

Verification
REQ-026 One-shot:
- Stimulus: write PRESET=3 at edge -1, then CTRL=0x9 (IM=1, Mode 0, Enable=1) at edge 0.
- Required response:
  - Edge 2: COUNT=3.
  - Edge 3: COUNT=2.
  - Edge 4: COUNT=1.
  - Edge 5: COUNT=0 and IRQ=1.
  - Edge 6: CTRL reads 0x8.
  - IRQ stays 1 until a CTRL write, then reads 0.
REQ-027 Auto-reload:
- Stimulus: PRESET=2, CTRL=0xB (IM=1, Mode 1, Enable=1).
- Required response: IRQ is high for exactly 1 cycle every 4 cycles; COUNT sequence 2,1,0,(INT),2,1,0...
REQ-028 Masked:
- Stimulus: PRESET=2, CTRL=0x1 (IM=0, Mode 0, Enable=1).
- Required response:
  - IRQ stays 0 throughout.
  - After expiry, writing CTRL=0x8 leaves IRQ=0, because pending was cleared by that write.
REQ-029 Pause:
- Stimulus: PRESET=10, Enable=1; after COUNT reaches 7, write CTRL=0x0.
- Required response: COUNT holds at a value between 6 and 7, and the state is IDLE.
- Stimulus: then write CTRL=0x1.
- Required response: COUNT reloads to 10.
REQ-030 Bus edges:
- Stimulus: write COUNT and Addr 3 with 0xFFFFFFFF.
- Required response: no register changes; Addr 3 reads 0; CTRL bits [31:4] read 0 after writing 0xFFFFFFFF to CTRL.
REQ-031 Reset mid-count:
- Stimulus: PRESET=5, Enable=1; pulse reset=0 for less than a clock period, between clock edges, while COUNT=3.
- Required response: all registers read 0 immediately; IRQ=0; no later activity.
